segment_swap_ctl: RTL and testbench
===================================

Name: segment_swap_ctl

Overview:
Sequences playback of a double-buffered (two-segment) sample memory, used for both modulation and STM. It generates the read index and the active segment, counts loop repetitions and performs glitch-free segment swaps only at loop boundaries. It sits between the register-file outputs (requested read segment, cycle, repetition) plus the frequency-divider step pulse, and the BRAM read-address path.

Parameters:
IDX_WIDTH, 15, width of sample index and cycle registers (32768 entries per segment)
REP_WIDTH, 16, width of repetition count; all-ones means infinite loop

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
UPDATE_SETTINGS  in  1  one-cycle pulse: latch a new playback request
REQ_RD_SEGMENT  in  1  requested segment (0/1)
CYCLE_0  in  IDX_WIDTH  last valid index (length-1) of segment 0
CYCLE_1  in  IDX_WIDTH  last valid index of segment 1
REP_0  in  REP_WIDTH  repetition setting for segment 0
REP_1  in  REP_WIDTH  repetition setting for segment 1
STEP  in  1  one-cycle pulse from the frequency divider: advance index
IDX  out  IDX_WIDTH  current read index
SEGMENT  out  1  current read segment
STOPPED  out  1  high while holding after finite repetitions are exhausted
SWAP  out  1  one-cycle pulse when a segment swap takes effect

Behaviour:
- Internal registers: req_seg, req_cycle, req_rep (pending request), act_cycle, act_rep, loop_cnt (REP_WIDTH), state.
- Reset values: IDX=0, SEGMENT=0, STOPPED=0, SWAP=0, act_cycle=0, act_rep=all-ones, loop_cnt=0, state=RUN.
- All outputs are registered; an effect caused by STEP or UPDATE_SETTINGS in cycle n is visible in cycle n+1.
- UPDATE_SETTINGS latches req_seg=REQ_RD_SEGMENT, req_cycle/req_rep from the CYCLE_x/REP_x selected by REQ_RD_SEGMENT. Valid in any state. Moves RUN or HOLD to PENDING. In PENDING it overwrites the pending request (last request wins).
- Boundary condition: STEP=1 and IDX==act_cycle.
- RUN:
  - STEP off-boundary: IDX+1.
  - Boundary with act_rep all-ones: IDX=0.
  - Boundary with finite act_rep and loop_cnt<act_rep: IDX=0, loop_cnt+1.
  - Boundary with finite act_rep and loop_cnt==act_rep: go to HOLD; IDX stays at act_cycle; STOPPED=1.
  - act_rep=0 therefore plays exactly one loop.
- PENDING:
  - Stepping as in RUN, but the boundary performs the swap instead of the wrap/repetition logic.
  - Swap: SEGMENT=req_seg, act_cycle=req_cycle, act_rep=req_rep, IDX=0, loop_cnt=0, STOPPED=0, SWAP=1 for one cycle, then RUN.
  - A request for the same segment is a restart: it still waits for the boundary, and SWAP still pulses.
- HOLD: STEP is ignored. IDX already equals act_cycle, so after UPDATE_SETTINGS (to PENDING) the next STEP swaps.
- UPDATE_SETTINGS and a boundary STEP in the same cycle: the swap uses the newly presented request values (bypass mux), not the previously latched ones.
- CYCLE_x/REP_x changes without UPDATE_SETTINGS have no effect; the active cycle is only ever taken at swap.
- act_cycle=0: every STEP is a boundary, so a finite act_rep counts single-sample loops.
- loop_cnt never exceeds act_rep, so it cannot overflow.
- RST mid-operation: immediate return to reset values; any pending request is discarded.

Decomposition:
- Shared package: segment-state enum (RUN, PENDING, HOLD); the infinite-repetition constant defined as all-ones of REP_WIDTH.
- Instantiate twice: once for modulation (IDX_WIDTH 15) and once for STM (IDX_WIDTH sized to STM depth).
- Natural sub-module: segment_loop_counter, holding the IDX/loop_cnt counting and boundary detection. The FSM stays in the parent.

Test Plan:
- Post-reset, no UPDATE, 3 STEPs -> IDX stays 0, SEGMENT=0, SWAP never asserted.
- UPDATE(seg0, CYCLE_0=3, REP_0=all-ones) then 10 STEPs -> one SWAP at the first STEP, then IDX 0,1,2,3,0,1,2,3,0,1; STOPPED=0.
- Segment 0 running (cycle 3) at IDX=1, UPDATE(seg1, CYCLE_1=1, REP_1=1), STEPs -> IDX 2,3, then SWAP with SEGMENT=1, IDX=0, then 1,0,1 with STOPPED=1 holding IDX=1; further STEPs leave IDX=1.
- While in HOLD on seg1, UPDATE(seg0, REP_0=0) + STEP -> SWAP, SEGMENT=0, IDX=0; after CYCLE_0+1 STEPs -> STOPPED=1, IDX=CYCLE_0.
- PENDING seg1 plus a new UPDATE(seg0) coincident with a boundary STEP -> swap lands on seg0 using CYCLE_0/REP_0 presented that cycle.
- RST asserted mid-PENDING -> next cycle IDX=0, SEGMENT=0, STOPPED=0; the subsequent boundary produces no SWAP.

Source files
------------

// File: rtl/segment_swap_ctl_pkg.sv
// Shared types and constants for the double-buffered segment playback sequencer.
package segment_swap_ctl_pkg;

    // Playback sequencer states.
    typedef enum logic [1:0] {
        SEG_RUN     = 2'd0,
        SEG_PENDING = 2'd1,
        SEG_HOLD    = 2'd2
    } seg_state_e;

    localparam int unsigned DEF_IDX_WIDTH = 15;
    localparam int unsigned DEF_REP_WIDTH = 16;

    // Repetition setting meaning "loop forever" (all-ones at the default width).
    localparam logic [DEF_REP_WIDTH-1:0] REP_INFINITE = '1;

endpackage

// File: rtl/segment_loop_counter.sv
// Sample index and loop-repetition counter with boundary detection.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   step          - raw step pulse (used for boundary detection)
//   step_en       - step accepted by the sequencer (not holding)
//   wrap_en       - apply wrap/repetition logic at the boundary (no swap pending)
//   clear         - swap: restart at index 0 with loop count 0
//   act_cycle     - last valid index of the active segment
//   act_rep       - repetition setting of the active segment
//   idx           - registered read index
//   boundary_c    - step arrives at the last index
//   exhausted_c   - boundary with finite repetitions used up
module segment_loop_counter
    import segment_swap_ctl_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = DEF_IDX_WIDTH,
    parameter int unsigned REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step,
    input  logic                 step_en,
    input  logic                 wrap_en,
    input  logic                 clear,
    input  logic [IDX_WIDTH-1:0] act_cycle,
    input  logic [REP_WIDTH-1:0] act_rep,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 boundary_c,
    output logic                 exhausted_c
);

    localparam logic [REP_WIDTH-1:0] REP_INF = '1;

    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [REP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
    logic                 rep_finite_c;

    assign rep_finite_c = (act_rep != REP_INF);
    assign boundary_c   = step && (idx_q == act_cycle);
    // loop_cnt never passes act_rep, so equality marks the final loop.
    assign exhausted_c  = boundary_c && rep_finite_c && (loop_cnt_q == act_rep);
    assign idx          = idx_q;

    // Next index / loop count.
    always_comb begin
        idx_d      = idx_q;
        loop_cnt_d = loop_cnt_q;
        if (clear) begin
            idx_d      = '0;
            loop_cnt_d = '0;
        end else if (step_en && !boundary_c) begin
            idx_d = IDX_WIDTH'(idx_q + 1'b1);
        end else if (step_en && wrap_en && boundary_c) begin
            if (!rep_finite_c) begin
                idx_d = '0;
            end else if (loop_cnt_q != act_rep) begin
                idx_d      = '0;
                loop_cnt_d = REP_WIDTH'(loop_cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            loop_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end

endmodule

// File: rtl/segment_swap_ctl.sv
// Two-segment playback sequencer: steps the read index, counts repetitions and
// swaps segments glitch-free only at loop boundaries.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   UPDATE_SETTINGS   - pulse: latch a new playback request
//   REQ_RD_SEGMENT    - requested segment
//   CYCLE_0/1, REP_0/1- per-segment last index and repetition setting
//   STEP              - advance pulse from the frequency divider
//   IDX, SEGMENT      - registered read index and segment
//   STOPPED           - holding after finite repetitions are exhausted
//   SWAP              - one-cycle pulse when a swap takes effect
module segment_swap_ctl
    import segment_swap_ctl_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = DEF_IDX_WIDTH,
    parameter int unsigned REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UPDATE_SETTINGS,
    input  logic                 REQ_RD_SEGMENT,
    input  logic [IDX_WIDTH-1:0] CYCLE_0,
    input  logic [IDX_WIDTH-1:0] CYCLE_1,
    input  logic [REP_WIDTH-1:0] REP_0,
    input  logic [REP_WIDTH-1:0] REP_1,
    input  logic                 STEP,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 SEGMENT,
    output logic                 STOPPED,
    output logic                 SWAP
);

    localparam logic [REP_WIDTH-1:0] REP_INF = '1;

    seg_state_e           state_q, state_d;
    logic                 req_seg_q, req_seg_d;
    logic [IDX_WIDTH-1:0] req_cycle_q, req_cycle_d;
    logic [REP_WIDTH-1:0] req_rep_q, req_rep_d;
    logic [IDX_WIDTH-1:0] act_cycle_q, act_cycle_d;
    logic [REP_WIDTH-1:0] act_rep_q, act_rep_d;
    logic                 segment_q, segment_d;
    logic                 stopped_q, stopped_d;
    logic                 swap_q, swap_d;

    logic                 pend_c;
    logic                 step_en_c;
    logic                 swap_c;
    logic                 boundary_c;
    logic                 exhausted_c;
    logic                 new_seg_c;
    logic [IDX_WIDTH-1:0] new_cycle_c;
    logic [REP_WIDTH-1:0] new_rep_c;

    // A request presented this cycle is live immediately, so a coincident
    // boundary swaps to it rather than to the older latched request.
    assign pend_c      = (state_q == SEG_PENDING) || UPDATE_SETTINGS;
    assign step_en_c   = STEP && ((state_q != SEG_HOLD) || UPDATE_SETTINGS);
    assign swap_c      = pend_c && boundary_c;
    assign new_seg_c   = UPDATE_SETTINGS ? REQ_RD_SEGMENT : req_seg_q;
    assign new_cycle_c = UPDATE_SETTINGS ? (REQ_RD_SEGMENT ? CYCLE_1 : CYCLE_0) : req_cycle_q;
    assign new_rep_c   = UPDATE_SETTINGS ? (REQ_RD_SEGMENT ? REP_1 : REP_0) : req_rep_q;

    segment_loop_counter #(
        .IDX_WIDTH (IDX_WIDTH),
        .REP_WIDTH (REP_WIDTH)
    ) u_loop_counter (
        .clk         (CLK),
        .rst         (RST),
        .step        (STEP),
        .step_en     (step_en_c),
        .wrap_en     (!pend_c),
        .clear       (swap_c),
        .act_cycle   (act_cycle_q),
        .act_rep     (act_rep_q),
        .idx         (IDX),
        .boundary_c  (boundary_c),
        .exhausted_c (exhausted_c)
    );

    // Next-state, request latch and swap logic.
    always_comb begin
        state_d     = state_q;
        req_seg_d   = req_seg_q;
        req_cycle_d = req_cycle_q;
        req_rep_d   = req_rep_q;
        act_cycle_d = act_cycle_q;
        act_rep_d   = act_rep_q;
        segment_d   = segment_q;
        stopped_d   = stopped_q;
        swap_d      = 1'b0;

        if (UPDATE_SETTINGS) begin
            req_seg_d   = new_seg_c;
            req_cycle_d = new_cycle_c;
            req_rep_d   = new_rep_c;
        end

        if (swap_c) begin
            segment_d   = new_seg_c;
            act_cycle_d = new_cycle_c;
            act_rep_d   = new_rep_c;
            stopped_d   = 1'b0;
            swap_d      = 1'b1;
            state_d     = SEG_RUN;
        end else if (UPDATE_SETTINGS) begin
            state_d = SEG_PENDING;
        end else begin
            case (state_q)
                SEG_RUN: begin
                    if (exhausted_c) begin
                        stopped_d = 1'b1;
                        state_d   = SEG_HOLD;
                    end
                end
                SEG_PENDING: ;
                SEG_HOLD:    ;
                default:     state_d = SEG_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= SEG_RUN;
            req_seg_q   <= 1'b0;
            req_cycle_q <= '0;
            req_rep_q   <= '0;
            act_cycle_q <= '0;
            act_rep_q   <= REP_INF;
            segment_q   <= 1'b0;
            stopped_q   <= 1'b0;
            swap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_seg_q   <= req_seg_d;
            req_cycle_q <= req_cycle_d;
            req_rep_q   <= req_rep_d;
            act_cycle_q <= act_cycle_d;
            act_rep_q   <= act_rep_d;
            segment_q   <= segment_d;
            stopped_q   <= stopped_d;
            swap_q      <= swap_d;
        end
    end

    assign SEGMENT = segment_q;
    assign STOPPED = stopped_q;
    assign SWAP    = swap_q;

endmodule

// File: tb/tb_segment_swap_ctl.sv
// Scoreboard bench for segment_swap_ctl: directed test-plan sequences followed by
// random traffic, all predicted by a behavioural playback model.
module tb_segment_swap_ctl;

    localparam int unsigned IW = 15;
    localparam int unsigned RW = 16;
    localparam logic [RW-1:0] INF = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd;
    logic          req_seg;
    logic [IW-1:0] cycle_0, cycle_1;
    logic [RW-1:0] rep_0, rep_1;
    logic          step;
    logic [IW-1:0] idx;
    logic          segment, stopped, swap;

    segment_swap_ctl #(.IDX_WIDTH(IW), .REP_WIDTH(RW)) dut (
        .CLK             (clk),
        .RST             (rst),
        .UPDATE_SETTINGS (upd),
        .REQ_RD_SEGMENT  (req_seg),
        .CYCLE_0         (cycle_0),
        .CYCLE_1         (cycle_1),
        .REP_0           (rep_0),
        .REP_1           (rep_1),
        .STEP            (step),
        .IDX             (idx),
        .SEGMENT         (segment),
        .STOPPED         (stopped),
        .SWAP            (swap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic          seg;
        logic          stopped;
        logic          swap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural playback model.
    int unsigned m_idx, m_cycle, m_rep, m_loops;
    bit          m_seg, m_stopped, m_swap, m_pending, m_holding;
    bit          r_seg;
    int unsigned r_cycle, r_rep;

    function automatic void model_reset();
        m_idx = 0; m_cycle = 0; m_rep = INF; m_loops = 0;
        m_seg = 0; m_stopped = 0; m_swap = 0; m_pending = 0; m_holding = 0;
        r_seg = 0; r_cycle = 0; r_rep = 0;
    endfunction

    function automatic void model_tick();
        bit          want;
        bit          at_end;
        bit          moving;
        bit          n_seg;
        int unsigned n_cycle, n_rep;
        if (rst) begin
            model_reset();
            return;
        end
        m_swap  = 0;
        want    = m_pending || upd;
        n_seg   = upd ? req_seg : r_seg;
        n_cycle = upd ? (req_seg ? cycle_1 : cycle_0) : r_cycle;
        n_rep   = upd ? (req_seg ? rep_1 : rep_0) : r_rep;
        at_end  = step && (m_idx == m_cycle);
        moving  = step && (!m_holding || upd);
        if (upd) begin
            r_seg = n_seg; r_cycle = n_cycle; r_rep = n_rep;
        end
        if (want && at_end) begin
            m_seg = n_seg; m_cycle = n_cycle; m_rep = n_rep;
            m_idx = 0; m_loops = 0; m_stopped = 0; m_swap = 1;
            m_pending = 0; m_holding = 0;
        end else begin
            if (upd) begin
                m_pending = 1; m_holding = 0;
            end
            if (moving && !at_end) begin
                m_idx = m_idx + 1;
            end else if (moving && at_end) begin
                if (m_rep == INF) m_idx = 0;
                else if (m_loops < m_rep) begin
                    m_idx = 0; m_loops = m_loops + 1;
                end else begin
                    m_holding = 1; m_stopped = 1;
                end
            end
        end
    endfunction

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic cyc(input bit r, input bit u, input bit s, input bit st,
                       input int unsigned c0, input int unsigned c1,
                       input int unsigned p0, input int unsigned p1);
        exp_t e;
        @(negedge clk);
        rst = r; upd = u; req_seg = s; step = st;
        cycle_0 = IW'(c0); cycle_1 = IW'(c1); rep_0 = RW'(p0); rep_1 = RW'(p1);
        model_tick();
        e.idx = IW'(m_idx); e.seg = m_seg; e.stopped = m_stopped; e.swap = m_swap;
        exp_q.push_back(e);
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 3, 1, INF, 1);
    endtask

    // Monitor: every cycle the DUT presents a registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks += 4;
                if (idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL idx: got %0d expected %0d at %0t", idx, e.idx, $time);
                end
                if (segment !== e.seg) begin
                    n_fail++;
                    $display("FAIL segment: got %b expected %b at %0t", segment, e.seg, $time);
                end
                if (stopped !== e.stopped) begin
                    n_fail++;
                    $display("FAIL stopped: got %b expected %b at %0t", stopped, e.stopped, $time);
                end
                if (swap !== e.swap) begin
                    n_fail++;
                    $display("FAIL swap: got %b expected %b at %0t", swap, e.swap, $time);
                end
            end
        end
    end

    initial begin
        int unsigned c0, c1, p0, p1, guard;
        rst = 1; upd = 0; req_seg = 0; step = 0;
        cycle_0 = '0; cycle_1 = '0; rep_0 = '0; rep_1 = '0;
        model_reset();

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Post-reset steps without a request.
        stepn(3);
        // Segment 0, cycle 3, infinite loop.
        cyc(0, 1, 0, 0, 3, 1, INF, 1);
        stepn(10);
        // Request segment 1 (cycle 1, rep 1) while at index 1.
        cyc(0, 1, 1, 0, 3, 1, INF, 1);
        stepn(9);
        // From HOLD: segment 0, cycle 2, single loop.
        cyc(0, 1, 0, 0, 2, 1, 0, 1);
        stepn(5);
        // PENDING seg1, then seg0 request coincident with a boundary step.
        cyc(0, 0, 0, 0, 4, 1, INF, 1);
        cyc(0, 1, 0, 1, 4, 1, INF, 1);
        stepn(2);
        cyc(0, 1, 1, 0, 4, 2, INF, 3);
        guard = 0;
        while (m_idx != m_cycle && guard < 20) begin
            cyc(0, 0, 0, 1, 4, 2, INF, 3);
            guard++;
        end
        cyc(0, 1, 0, 1, 2, 2, 1, 3);
        stepn(6);
        // Reset while a request is pending.
        cyc(0, 1, 1, 0, 2, 2, 1, 3);
        cyc(1, 0, 0, 0, 2, 2, 1, 3);
        stepn(4);
        // Coincident update with a boundary step from RUN and from HOLD.
        cyc(0, 1, 1, 1, 0, 0, 0, 0);
        stepn(2);
        cyc(0, 1, 0, 1, 1, 0, 2, 0);
        stepn(3);

        // Random traffic with small cycles so boundaries are frequent.
        for (int i = 0; i < 4000; i++) begin
            c0 = $urandom_range(0, 5);
            c1 = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0: p0 = 0; 1: p0 = 1; 2: p0 = 2; default: p0 = INF;
            endcase
            case ($urandom_range(0, 3))
                0: p1 = 0; 1: p1 = 1; 2: p1 = 3; default: p1 = INF;
            endcase
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                c0, c1, p0, p1);
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
